gpcfg_wr: RTL
=============

// Module: gpcfg_wr
// PURPOSE
//  Write side of one general-purpose config register on the AHB-lite config bus.
//  - Captures a write address phase, then merges the next cycle's data phase into the
//    register under byte enables.
//  - Holds the register value and drives it into the block's datapath and to the
//    config read mux.
//  - Adds read-only bit masking, self-clearing pulse bits and a one-cycle update strobe.
// PARAMETERS
//  CFG_ADDR    16'h0      register offset, compared against wr_addr[15:0]
//  RESET_VAL   32'h0      wr_reg value on reset; also the idle value of pulse bits
//  RO_MASK     32'h0      1 = bit not writable, always holds RESET_VAL
//  PULSE_MASK  32'h0      1 = bit self-clears to RESET_VAL one cycle after being written
// PORTS
//  hclk      in   1   clock, all state on posedge
//  hresetn   in   1   reset, asynchronous, active-low
//  wr_en     in   1   address-phase write request (HSEL & HWRITE & HTRANS valid & HREADY)
//  wr_addr   in   32  address-phase address, only [15:0] decoded
//  byte_en   in   4   address-phase byte lane enables, bit i = wdata[8i+7:8i]
//  wdata     in   32  data-phase write data, valid the cycle after the address phase
//  wr_reg    out  32  current register value
//  wr_upd    out  1   one-cycle strobe, high in the first cycle a new value is visible
// BEHAVIOUR
//  Reset (async, hresetn=0): wr_reg=RESET_VAL, wr_upd=0, FSM=IDLE, pend_be=0.
//  FSM, state register plus pend_be[3:0]:
//   IDLE -> DATA  when wr_en & (wr_addr[15:0]==CFG_ADDR); pend_be <= byte_en.
//   DATA -> DATA  same condition true again (back-to-back writes); pend_be reloads.
//   DATA -> IDLE  otherwise.
//  Data phase (state==DATA) at the posedge:
//   Lanes with pend_be[i]=1 load wdata into bits where RO_MASK=0.
//   RO bits always stay RESET_VAL. Other lanes hold their value.
//   wr_upd <= |pend_be. A matched write with byte_en=0 changes nothing, no strobe.
//  Latency: address phase at edge N, data phase at edge N+1.
//   New wr_reg and wr_upd=1 are visible after edge N+1.
//   wr_upd drops after edge N+2 unless another data phase lands.
//  Pulse bits (PULSE_MASK=1, RO_MASK=0):
//   - Return to RESET_VAL at the edge after the one that wrote them.
//   - High for exactly one cycle per write.
//   - A data phase on the same edge as the clear has priority, so the bit stays written.
//  Address mismatch or wr_en=0: no state change except pulse-bit clear and wr_upd drop.
//  No wait states: the block never stalls the bus; HREADYOUT is generated elsewhere.
//  Reset mid-operation: a pending data phase is discarded and the write is lost.
//   After release the FSM is in IDLE.
//  wdata is sampled only in DATA. X on wdata in other cycles must not propagate.
// STRUCTURE
//  Shared package gpcfg_pkg, also used by the read mux:
//   CFG_AW=16, CFG_DW=32, CFG_NLANE=4, state encoding typedef (IDLE=1'b0, DATA=1'b1).
//  Sub-module gpcfg_wr_lane, instantiated CFG_NLANE times:
//   8-bit lane register with lane slices of RESET_VAL, RO_MASK and PULSE_MASK.
//   Inputs: we, d, clear.
//  Top level holds the FSM, address decode, pend_be and wr_upd.
// TESTING
//  1 Reset, RESET_VAL=32'hA5A5_0000: release reset -> wr_reg=32'hA5A5_0000, wr_upd=0.
//  2 Full write: wr_en=1, addr=16'h0, be=4'hF, then wdata=32'h1234_5678
//    -> wr_reg=32'h1234_5678 one edge after the data phase; wr_upd high 1 cycle.
//  3 Byte write: be=4'b0100, wdata=32'hFFFF_FFFF on reg 32'h0 -> wr_reg=32'h00FF_0000.
//    Repeat with be=0 -> no change, wr_upd=0.
//  4 Masks: RO_MASK=32'h0000_00FF, PULSE_MASK=32'h8000_0000; write 32'hFFFF_FFFF, be=F
//    -> wr_reg=32'hFFFF_FF00 for 1 cycle, then 32'h7FFF_FF00.
//  5 Back-to-back: three consecutive address phases with data 1,2,3
//    -> wr_reg steps 1,2,3 on consecutive edges; wr_upd high 3 cycles.
//    Also addr=16'h4 -> ignored.
//  6 Reset mid-op: assert hresetn=0 between address and data phase
//    -> wr_reg=RESET_VAL; the dropped data phase is never applied after release.

Source files
------------

// File: rtl/gpcfg_pkg.sv
// rtl/gpcfg_pkg.sv - shared widths, state encoding and decode helper for the gpcfg register blocks
package gpcfg_pkg;

  localparam int CFG_AW    = 16;
  localparam int CFG_DW    = 32;
  localparam int CFG_NLANE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } gpcfg_state_e;

  function automatic logic addr_hit(input logic [CFG_AW-1:0] addr,
                                    input logic [CFG_AW-1:0] cfg_addr);
    return addr == cfg_addr;
  endfunction

endpackage

// File: rtl/gpcfg_wr_if.sv
// rtl/gpcfg_wr_if.sv - config-bus write port and register readback of one gpcfg register
interface gpcfg_wr_if;
  import gpcfg_pkg::*;

  logic                 wr_en;
  logic [CFG_DW-1:0]    wr_addr;
  logic [CFG_NLANE-1:0] byte_en;
  logic [CFG_DW-1:0]    wdata;
  logic [CFG_DW-1:0]    wr_reg;
  logic                 wr_upd;

  modport master (
    output wr_en, wr_addr, byte_en, wdata,
    input  wr_reg, wr_upd
  );

  modport slave (
    input  wr_en, wr_addr, byte_en, wdata,
    output wr_reg, wr_upd
  );

endinterface

// File: rtl/gpcfg_wr_lane.sv
// rtl/gpcfg_wr_lane.sv - one 8-bit byte lane of the register with read-only and pulse bits
module gpcfg_wr_lane
  import gpcfg_pkg::*;
#(
  parameter logic [7:0] RESET_VAL  = 8'h00,
  parameter logic [7:0] RO_MASK    = 8'h00,
  parameter logic [7:0] PULSE_MASK = 8'h00
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       we,
  input  logic       clear,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] q_next;
  logic [7:0] q_cleared;

  // A write on the same edge as the pulse clear wins, so the written bit survives.
  always_comb begin
    q_cleared = (q & ~PULSE_MASK) | (RESET_VAL & PULSE_MASK);
    q_next    = q;
    if (we) begin
      q_next = d;
    end else if (clear) begin
      q_next = q_cleared;
    end
    q_next = (q_next & ~RO_MASK) | (RESET_VAL & RO_MASK);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/gpcfg_wr.sv
// rtl/gpcfg_wr.sv - write side of one general-purpose config register (address/data phase merge)
module gpcfg_wr
  import gpcfg_pkg::*;
#(
  parameter logic [CFG_AW-1:0] CFG_ADDR   = '0,
  parameter logic [CFG_DW-1:0] RESET_VAL  = '0,
  parameter logic [CFG_DW-1:0] RO_MASK    = '0,
  parameter logic [CFG_DW-1:0] PULSE_MASK = '0
) (
  input logic        hclk,
  input logic        hresetn,
  gpcfg_wr_if.slave  bus
);

  gpcfg_state_e         state;
  gpcfg_state_e         state_next;
  logic [CFG_NLANE-1:0] pend_be;
  logic                 hit;
  logic                 data_phase;
  logic                 upd_q;
  logic [CFG_DW-1:0]    reg_q;
  logic                 addr_hi_unused;

  assign hit            = bus.wr_en && addr_hit(bus.wr_addr[CFG_AW-1:0], CFG_ADDR);
  assign addr_hi_unused = ^bus.wr_addr[CFG_DW-1:CFG_AW];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= IDLE;
      pend_be <= '0;
    end else begin
      state   <= state_next;
      pend_be <= hit ? bus.byte_en : '0;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = hit ? DATA : IDLE;
      DATA:    state_next = hit ? DATA : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_phase = 1'b0;
    case (state)
      DATA:    data_phase = 1'b1;
      default: data_phase = 1'b0;
    endcase
  end

  // The strobe doubles as the pulse-bit clear: pulse bits can only be set if a write landed last edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= data_phase && (|pend_be);
    end
  end

  for (genvar i = 0; i < CFG_NLANE; i++) begin : g_lane
    gpcfg_wr_lane #(
      .RESET_VAL  (RESET_VAL[8*i +: 8]),
      .RO_MASK    (RO_MASK[8*i +: 8]),
      .PULSE_MASK (PULSE_MASK[8*i +: 8])
    ) u_lane (
      .hclk    (hclk),
      .hresetn (hresetn),
      .we      (data_phase && pend_be[i]),
      .clear   (upd_q),
      .d       (bus.wdata[8*i +: 8]),
      .q       (reg_q[8*i +: 8])
    );
  end

  assign bus.wr_reg = reg_q;
  assign bus.wr_upd = upd_q;

endmodule
